// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI RAM-bridge master (and its slave peer).
//   CMD_WR / CMD_RD   : 2-bit frame command codes, sent MSB first
//   spi_state_e       : master FSM state encoding
//   DIV_RATIO_DEF     : default CLK cycles per SCLK period
//   cnt_last()        : helper giving the final index of an n-step count
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int DIV_RATIO_DEF = 10;

  localparam logic [1:0] CMD_WR = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WDAT = 3'd2,
    TURN = 3'd3,
    RDAT = 3'd4,
    GAP  = 3'd5
  } spi_state_e;

  // Final value of a 5-bit counter that has to cover n steps (0..n-1).
  function automatic logic [4:0] cnt_last(input int n);
    return 5'(n - 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// Divides CLK down to SCLK while the frame is active.
//   CLK, RST     : system clock, synchronous active-high reset
//   EN           : high while chip select is asserted (CSN low)
//   SCLK         : registered serial clock, low for the first half period
//   SHIFT_TICK   : DIV_CNT==0, first cycle of a period (SCLK falling edge)
//   SAMPLE_TICK  : DIV_CNT==DIV_RATIO/2, first SCLK-high cycle (rising edge)
//   PERIOD_END   : DIV_CNT==DIV_RATIO-1, last cycle of a period; state
//                  updated on this cycle becomes visible with DIV_CNT==0
// ---------------------------------------------------------------------------
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_RATIO = DIV_RATIO_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic SCLK,
  output logic SHIFT_TICK,
  output logic SAMPLE_TICK,
  output logic PERIOD_END
);

  localparam logic [3:0] CNT_LAST = 4'(DIV_RATIO - 1);
  localparam logic [3:0] CNT_HALF = 4'(DIV_RATIO / 2);

  if ((DIV_RATIO % 2) != 0 || DIV_RATIO < 4 || DIV_RATIO > 16) begin : g_bad_div
    $error("spi_sclk_gen: DIV_RATIO must be even and within 4..16");
  end

  logic [3:0] div_cnt_q, div_cnt_d;
  logic       sclk_q, sclk_d;

  // The divider is parked at zero whenever chip select is released, so
  // every frame starts on a clean period boundary. SCLK is derived from
  // the next count so that it stays registered yet aligned with DIV_CNT.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!EN) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 4'd1;
    end
    sclk_d = (div_cnt_d >= CNT_HALF);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign SCLK        = sclk_q;
  assign SHIFT_TICK  = EN && (div_cnt_q == 4'd0);
  assign SAMPLE_TICK = EN && (div_cnt_q == CNT_HALF);
  assign PERIOD_END  = EN && (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// SPI initiator issuing single-word RAM write/read frames to the SPI slave
// RAM bridge. Frame: 2-bit command, address, then data, MSB first. Reads
// insert one turnaround period after the address before MISO data.
//   CLK, RST  : system clock, synchronous active-high reset
//   START     : request, accepted only in IDLE (RW/ADDR_IN/WDATA sampled)
//   RW        : 1 = read, 0 = write
//   ADDR_IN   : RAM address
//   WDATA     : write data
//   BUSY      : high from the cycle after acceptance until back in IDLE
//   DONE      : one-cycle pulse in the first inter-frame gap cycle
//   RDATA     : last read result, changed only by read frames
//   CSN, SCLK, MOSI, MISO : SPI bus (CSN active-low, SCLK idles low)
// ---------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_BIT  = 4,
  parameter int ADDR_BIT  = 3,
  parameter int SPI_BIT   = 2 + ADDR_BIT + DATA_BIT,
  parameter int DIV_RATIO = DIV_RATIO_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                RW,
  input  logic [ADDR_BIT-1:0] ADDR_IN,
  input  logic [DATA_BIT-1:0] WDATA,
  output logic                BUSY,
  output logic                DONE,
  output logic [DATA_BIT-1:0] RDATA,
  output logic                CSN,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO
);

  localparam logic [4:0] CMD_LAST  = cnt_last(2 + ADDR_BIT);
  localparam logic [4:0] DATA_LAST = cnt_last(DATA_BIT);
  localparam logic [4:0] GAP_LAST  = cnt_last(DIV_RATIO);

  spi_state_e          state_q, state_d;
  logic [SPI_BIT-1:0]  sr_q, sr_d;
  logic [DATA_BIT-1:0] rx_q, rx_d;
  logic [DATA_BIT-1:0] rdata_q, rdata_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic                rw_q, rw_d;
  logic                csn_q, csn_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                shift_tick;
  logic                sample_tick;
  logic                period_end;
  logic [SPI_BIT-1:0]  start_frame;

  spi_sclk_gen #(
    .DIV_RATIO (DIV_RATIO)
  ) u_sclk_gen (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (~csn_q),
    .SCLK        (SCLK),
    .SHIFT_TICK  (shift_tick),
    .SAMPLE_TICK (sample_tick),
    .PERIOD_END  (period_end)
  );

  assign start_frame = {(RW ? CMD_RD : CMD_WR), ADDR_IN, WDATA};

  // Frame sequencing. All bus-visible updates are made on the last cycle of
  // an SCLK period so they appear together with DIV_CNT returning to zero,
  // i.e. MOSI only moves on the falling SCLK edge. BIT_CNT counts periods
  // within a phase and doubles as the cycle counter during GAP, where the
  // divider is parked.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    csn_d     = csn_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = CMD;
          sr_d      = start_frame;
          rw_d      = RW;
          csn_d     = 1'b0;
          mosi_d    = start_frame[SPI_BIT-1];
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end

      CMD: begin
        if (period_end) begin
          if (bit_cnt_q == CMD_LAST) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d = TURN;
              mosi_d  = 1'b0;
            end else begin
              state_d = WDAT;
              sr_d    = sr_q << 1;
              mosi_d  = sr_q[SPI_BIT-2];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            sr_d      = sr_q << 1;
            mosi_d    = sr_q[SPI_BIT-2];
          end
        end
      end

      WDAT: begin
        if (period_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = GAP;
            bit_cnt_d = '0;
            csn_d     = 1'b1;
            mosi_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            sr_d      = sr_q << 1;
            mosi_d    = sr_q[SPI_BIT-2];
          end
        end
      end

      // The slave is fetching RAM data here; MISO may be undefined, so the
      // receive register is only cleared, never loaded from the bus.
      TURN: begin
        if (shift_tick) begin
          rx_d = '0;
        end
        if (period_end) begin
          state_d   = RDAT;
          bit_cnt_d = '0;
          mosi_d    = 1'b0;
        end
      end

      RDAT: begin
        if (sample_tick) begin
          rx_d = DATA_BIT'({rx_q, MISO});
        end
        if (period_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = GAP;
            bit_cnt_d = '0;
            rdata_d   = rx_q;
            csn_d     = 1'b1;
            mosi_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      GAP: begin
        if (bit_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          busy_d    = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        csn_d     = 1'b1;
        mosi_d    = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      csn_q     <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      csn_q     <= csn_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign RDATA = rdata_q;
  assign CSN   = csn_q;
  assign MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master with a behavioural SPI slave RAM model.
// ---------------------------------------------------------------------------
module tb_spi_master;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       RW = 1'b0;
  logic [2:0] ADDR_IN = '0;
  logic [3:0] WDATA = '0;
  logic       BUSY, DONE, CSN, SCLK, MOSI;
  logic [3:0] RDATA;
  logic       miso = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  spi_master dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .RW      (RW),
    .ADDR_IN (ADDR_IN),
    .WDATA   (WDATA),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .RDATA   (RDATA),
    .CSN     (CSN),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (miso)
  );

  always #5 CLK = ~CLK;

  // Slave RAM model and bus monitor, sampled on the falling CLK edge.
  logic [3:0] mem [8] = '{4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
  logic       mosi_log [1:16];
  int         rise_cnt = 0;
  int         frame_cnt = 0;
  int         done_cnt = 0;
  int         low_cnt = 0;
  int         high_cnt = 0;
  int         last_low_len = 0;
  int         gap_len [32];
  int         busy_rises = 0;
  int         busy_low_run = 0;
  int         busy_low_len [32];
  logic [3:0] rdata_at_done = '0;
  logic       prev_csn = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_busy = 1'b0;
  logic       done_long = 1'b0;
  logic       x_seen = 1'b0;

  always @(negedge CLK) begin
    logic [2:0] a;
    a = {mosi_log[3], mosi_log[4], mosi_log[5]};
    if (CSN === 1'b0) begin
      if (prev_csn === 1'b1) begin
        frame_cnt++;
        gap_len[frame_cnt % 32] = high_cnt;
        low_cnt  = 0;
        rise_cnt = 0;
        for (int i = 1; i <= 16; i++) mosi_log[i] = 1'b0;
      end
      low_cnt++;
      if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
        rise_cnt++;
        if (rise_cnt <= 16) mosi_log[rise_cnt] = MOSI;
      end
      if (SCLK === 1'b0 && prev_sclk === 1'b1 &&
          mosi_log[1] === 1'b0 && mosi_log[2] === 1'b1) begin
        if (rise_cnt == 5) miso = 1'bx;
        else if (rise_cnt >= 6 && rise_cnt <= 9) miso = mem[a][9 - rise_cnt];
      end
    end else begin
      if (prev_csn === 1'b0) begin
        last_low_len = low_cnt;
        high_cnt = 0;
        miso = 1'b0;
        if (rise_cnt == 9 && mosi_log[1] === 1'b1 && mosi_log[2] === 1'b0)
          mem[a] = {mosi_log[6], mosi_log[7], mosi_log[8], mosi_log[9]};
      end
      high_cnt++;
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      rdata_at_done = RDATA;
      if (prev_done === 1'b1) done_long = 1'b1;
    end
    if (BUSY === 1'b1) begin
      if (prev_busy !== 1'b1) begin
        busy_rises++;
        busy_low_len[busy_rises % 32] = busy_low_run;
      end
      busy_low_run = 0;
    end else begin
      busy_low_run++;
    end
    if ($isunknown(RDATA)) x_seen = 1'b1;
    prev_csn  = CSN;
    prev_sclk = SCLK;
    prev_done = DONE;
    prev_busy = BUSY;
  end

  task automatic start_frame(input logic rw, input logic [2:0] a, input logic [3:0] d);
    @(negedge CLK);
    START = 1'b1; RW = rw; ADDR_IN = a; WDATA = d;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY !== 1'b0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL %s_timeout: BUSY=%b, required 0 within 400 cycles", name, BUSY);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run++; if (CSN !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_csn: got %b, want 1", CSN); end
    tests_run++; if (SCLK !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sclk: got %b, want 0", SCLK); end
    tests_run++; if (MOSI !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mosi: got %b, want 0", MOSI); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, want 0", BUSY); end
    tests_run++; if (DONE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b, want 0", DONE); end
    tests_run++; if (RDATA !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h, want 0", RDATA); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_write;
    int base_done = done_cnt;
    logic [8:0] v = '0;
    start_frame(1'b0, 3'd5, 4'hA);
    tests_run++; if (CSN !== 1'b0 || BUSY !== 1'b1 || MOSI !== 1'b1 || SCLK !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL wr_first_cycle: csn/busy/mosi/sclk=%b%b%b%b, want 0110", CSN, BUSY, MOSI, SCLK); end
    wait_idle("wr");
    for (int i = 1; i <= 9; i++) v = {v[7:0], mosi_log[i]};
    tests_run++; if (v !== 9'b101011010) begin tests_failed++; $display("[TB] FAIL wr_mosi: got %b, want 101011010", v); end
    tests_run++; if (last_low_len != 90) begin tests_failed++; $display("[TB] FAIL wr_csn_low: got %0d, want 90", last_low_len); end
    tests_run++; if (done_cnt - base_done != 1 || done_long) begin
      tests_failed++; $display("[TB] FAIL wr_done: got %0d pulses (long=%b), want 1", done_cnt - base_done, done_long); end
    tests_run++; if (mem[5] !== 4'hA) begin tests_failed++; $display("[TB] FAIL wr_ram5: got %h, want A", mem[5]); end
    tests_run++; if (RDATA !== 4'h0) begin tests_failed++; $display("[TB] FAIL wr_rdata_kept: got %h, want 0", RDATA); end
  endtask

  task automatic test_read;
    logic [5:0] v = '0;
    start_frame(1'b1, 3'd3, 4'h0);
    wait_idle("rd");
    for (int i = 1; i <= 6; i++) v = {v[4:0], mosi_log[i]};
    tests_run++; if (v !== 6'b010110) begin tests_failed++; $display("[TB] FAIL rd_mosi: got %b, want 010110", v); end
    tests_run++; if (last_low_len != 100) begin tests_failed++; $display("[TB] FAIL rd_csn_low: got %0d, want 100", last_low_len); end
    tests_run++; if (rdata_at_done !== 4'h6) begin tests_failed++; $display("[TB] FAIL rd_rdata_at_done: got %h, want 6", rdata_at_done); end
    tests_run++; if (RDATA !== 4'h6) begin tests_failed++; $display("[TB] FAIL rd_rdata: got %h, want 6", RDATA); end
  endtask

  task automatic test_loopback;
    start_frame(1'b0, 3'd2, 4'hC);
    wait_idle("lb_wr");
    start_frame(1'b1, 3'd2, 4'h0);
    wait_idle("lb_rd");
    tests_run++; if (RDATA !== 4'hC) begin tests_failed++; $display("[TB] FAIL lb_rdata: got %h, want C", RDATA); end
    tests_run++; if (x_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_rdata_x: x_seen=%b, want 0", x_seen); end
  endtask

  task automatic test_start_ignored;
    int base_done = done_cnt;
    int base_frames = frame_cnt;
    start_frame(1'b0, 3'd1, 4'h3);
    repeat (18) @(negedge CLK);
    START = 1'b1; RW = 1'b1; ADDR_IN = 3'd7;
    @(negedge CLK);
    START = 1'b0;
    wait_idle("ign");
    repeat (15) @(negedge CLK);
    tests_run++; if (frame_cnt - base_frames != 1) begin tests_failed++; $display("[TB] FAIL ign_frames: got %0d, want 1", frame_cnt - base_frames); end
    tests_run++; if (done_cnt - base_done != 1) begin tests_failed++; $display("[TB] FAIL ign_done: got %0d, want 1", done_cnt - base_done); end
    tests_run++; if (mem[1] !== 4'h3) begin tests_failed++; $display("[TB] FAIL ign_ram1: got %h, want 3", mem[1]); end
  endtask

  task automatic test_reset_mid;
    int base_done = done_cnt;
    start_frame(1'b1, 3'd4, 4'h0);
    repeat (38) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    tests_run++; if (CSN !== 1'b1 || SCLK !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL abort_outputs: csn/sclk/busy=%b%b%b, want 100", CSN, SCLK, BUSY); end
    RST = 1'b0;
    repeat (150) @(negedge CLK);
    tests_run++; if (done_cnt != base_done) begin tests_failed++; $display("[TB] FAIL abort_no_done: got %0d pulses, want 0", done_cnt - base_done); end
    start_frame(1'b0, 3'd6, 4'h9);
    wait_idle("post_abort");
    tests_run++; if (done_cnt - base_done != 1 || mem[6] !== 4'h9) begin
      tests_failed++; $display("[TB] FAIL post_abort_wr: done=%0d ram6=%h, want 1 and 9", done_cnt - base_done, mem[6]); end
  endtask

  task automatic test_back_to_back;
    int base_done = done_cnt;
    int base_frames = frame_cnt;
    int base_busy = busy_rises;
    int n = 0;
    @(negedge CLK);
    START = 1'b1; RW = 1'b0; ADDR_IN = 3'd7; WDATA = 4'h5;
    while (frame_cnt - base_frames < 3 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    tests_run++; if (frame_cnt - base_frames < 3) begin tests_failed++; $display("[TB] FAIL b2b_frames: got %0d, want 3", frame_cnt - base_frames); end
    wait_idle("b2b");
    repeat (15) @(negedge CLK);
    tests_run++; if (gap_len[(base_frames + 2) % 32] != 11 || gap_len[(base_frames + 3) % 32] != 11) begin
      tests_failed++; $display("[TB] FAIL b2b_csn_gap: got %0d,%0d, want 11,11", gap_len[(base_frames + 2) % 32], gap_len[(base_frames + 3) % 32]); end
    tests_run++; if (busy_low_len[(base_busy + 2) % 32] != 1 || busy_low_len[(base_busy + 3) % 32] != 1) begin
      tests_failed++; $display("[TB] FAIL b2b_busy_low: got %0d,%0d, want 1,1", busy_low_len[(base_busy + 2) % 32], busy_low_len[(base_busy + 3) % 32]); end
    tests_run++; if (done_cnt - base_done != 3 || mem[7] !== 4'h5) begin
      tests_failed++; $display("[TB] FAIL b2b_done: done=%0d ram7=%h, want 3 and 5", done_cnt - base_done, mem[7]); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_loopback;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
